// File: rtl/writeback_buffer.sv
// Single-entry eviction buffer for the data cache.
// Drains one dirty line as an 8-beat write burst and answers snoops while busy.
module writeback_buffer (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Evict,
    input  logic [31:0]  EvictAddress,
    input  logic [255:0] EvictLine,
    output logic         Ready,
    output logic [31:0]  BaseAddress,
    output logic         AXIStartWrite,
    input  logic         AddrAccepted,
    output logic [31:0]  WriteData,
    output logic         WriteValid,
    output logic         WriteLast,
    input  logic         WriteReady,
    input  logic         RespValid,
    input  logic         RespError,
    output logic         Done,
    output logic         Error,
    input  logic [31:0]  SnoopAddress,
    output logic         SnoopHit,
    output logic [31:0]  SnoopData
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        DATA,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [7:0][31:0]  buffer;
    logic [28:0]       base_line;
    logic [2:0]        counter;
    logic              done_q;
    logic              error_q;
    logic              unused_ok;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (Evict) state_nx = REQUEST;
            REQUEST: if (AddrAccepted) state_nx = DATA;
            DATA:    if (WriteReady && counter == 3'd7) state_nx = RESP;
            RESP:    if (RespValid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Buffer only loads on an accepted eviction; counter wraps to 0 after beat 7
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            buffer    <= '0;
            base_line <= '0;
            counter   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (Evict) begin
                        buffer    <= EvictLine;
                        base_line <= EvictAddress[31:3];
                        counter   <= '0;
                        error_q   <= 1'b0;
                    end
                end
                DATA: begin
                    if (WriteReady) counter <= counter + 3'd1;
                end
                RESP: begin
                    if (RespValid) begin
                        error_q <= RespError;
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Ready         = (state == IDLE);
    assign AXIStartWrite = (state == REQUEST);
    assign WriteValid    = (state == DATA);
    assign WriteLast     = (state == DATA) && (counter == 3'd7);
    assign WriteData     = buffer[counter];
    assign BaseAddress   = {base_line, 3'b000};
    assign Done          = done_q;
    assign Error         = error_q;

    // Lets a linefill of the in-flight line bypass stale memory
    assign SnoopHit  = (state != IDLE) && (SnoopAddress[31:3] == base_line);
    assign SnoopData = buffer[SnoopAddress[2:0]];

    assign unused_ok = ^EvictAddress[2:0];

endmodule

// File: tb/tb_writeback_buffer.sv
// Randomized bench for writeback_buffer against a transaction-level model.
// Inputs change on the falling edge; outputs are compared just before that.
module tb_writeback_buffer;

    logic         Clk;
    logic         Rst_n;
    logic         Evict;
    logic [31:0]  EvictAddress;
    logic [255:0] EvictLine;
    logic         Ready;
    logic [31:0]  BaseAddress;
    logic         AXIStartWrite;
    logic         AddrAccepted;
    logic [31:0]  WriteData;
    logic         WriteValid;
    logic         WriteLast;
    logic         WriteReady;
    logic         RespValid;
    logic         RespError;
    logic         Done;
    logic         Error;
    logic [31:0]  SnoopAddress;
    logic         SnoopHit;
    logic [31:0]  SnoopData;

    writeback_buffer dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Evict        (Evict),
        .EvictAddress (EvictAddress),
        .EvictLine    (EvictLine),
        .Ready        (Ready),
        .BaseAddress  (BaseAddress),
        .AXIStartWrite(AXIStartWrite),
        .AddrAccepted (AddrAccepted),
        .WriteData    (WriteData),
        .WriteValid   (WriteValid),
        .WriteLast    (WriteLast),
        .WriteReady   (WriteReady),
        .RespValid    (RespValid),
        .RespError    (RespError),
        .Done         (Done),
        .Error        (Error),
        .SnoopAddress (SnoopAddress),
        .SnoopHit     (SnoopHit),
        .SnoopData    (SnoopData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference: one line in flight, described by how far its burst has got
    bit          m_busy;
    bit          m_addr_ok;
    int          m_beats;
    logic [31:0] m_line [8];
    logic [31:0] m_base;
    bit          m_err;
    bit          m_done;

    bit stall_beat4;
    int stalls;
    bit hold_evict;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy    = 0;
        m_addr_ok = 0;
        m_beats   = 0;
        m_base    = '0;
        m_err     = 0;
        m_done    = 0;
        for (int i = 0; i < 8; i++) m_line[i] = '0;
    endtask

    task automatic model_edge();
        m_done = 0;
        if (!m_busy) begin
            if (Evict) begin
                m_busy    = 1;
                m_addr_ok = 0;
                m_beats   = 0;
                m_base    = EvictAddress & 32'hFFFF_FFF8;
                m_err     = 0;
                for (int i = 0; i < 8; i++) m_line[i] = EvictLine[32*i +: 32];
            end
        end else if (!m_addr_ok) begin
            if (AddrAccepted) m_addr_ok = 1;
        end else if (m_beats < 8) begin
            if (WriteReady) m_beats++;
        end else if (RespValid) begin
            m_err   = RespError;
            m_done  = 1;
            m_busy  = 0;
            m_beats = 0;
        end
    endtask

    task automatic check_outputs();
        bit dv;
        bit hit;
        dv  = m_busy && m_addr_ok && (m_beats < 8);
        hit = m_busy && (SnoopAddress[31:3] == m_base[31:3]);
        check("ready", 32'(Ready), 32'(!m_busy));
        check("base", BaseAddress, m_base);
        check("awvalid", 32'(AXIStartWrite), 32'(m_busy && !m_addr_ok));
        check("wvalid", 32'(WriteValid), 32'(dv));
        check("wlast", 32'(WriteLast), 32'(dv && m_beats == 7));
        check("wdata", WriteData, m_line[m_beats % 8]);
        check("done", 32'(Done), 32'(m_done));
        check("error", 32'(Error), 32'(m_err));
        check("snoophit", 32'(SnoopHit), 32'(hit));
        check("snoopdata", SnoopData, m_line[SnoopAddress[2:0]]);
    endtask

    task automatic step();
        @(posedge Clk);
        if (Rst_n) model_edge();
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic set_line(input logic [31:0] b);
        for (int i = 0; i < 8; i++) EvictLine[32*i +: 32] = b + 32'(i);
    endtask

    task automatic run_to_done(input int maxc, output int n);
        bit seen;
        seen   = 0;
        n      = 0;
        stalls = 0;
        while (!seen && n < maxc) begin
            if (stall_beat4 && m_busy && m_addr_ok && m_beats == 4 && stalls < 3) begin
                WriteReady = 0;
                stalls++;
            end else begin
                WriteReady = 1;
            end
            step();
            n++;
            if (!hold_evict) Evict = 0;
            if (Done) seen = 1;
        end
        if (!seen) check("timeout", 32'(n), 32'(maxc + 1));
    endtask

    int n;

    initial begin
        Rst_n = 0;
        Evict = 0;
        EvictAddress = '0;
        EvictLine = '0;
        AddrAccepted = 1;
        WriteReady = 1;
        RespValid = 1;
        RespError = 0;
        SnoopAddress = 32'h0000_1236;
        stall_beat4 = 0;
        hold_evict = 0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        check_outputs();
        Rst_n = 1;
        @(negedge Clk);

        // Basic burst, all handshakes high
        Evict = 1;
        EvictAddress = 32'h0000_1235;
        set_line(32'hA0);
        run_to_done(30, n);
        check("latency", 32'(n), 32'd11);
        check("base_aligned", BaseAddress, 32'h0000_1230);
        SnoopAddress = 32'h0000_1236;
        #1;
        check("snoop_after_done", 32'(SnoopHit), 32'd0);
        step();

        // Three-cycle stall on beat 4
        stall_beat4 = 1;
        Evict = 1;
        SnoopAddress = 32'h0000_1246;
        run_to_done(30, n);
        check("latency_stall", 32'(n), 32'd14);
        stall_beat4 = 0;

        // Evict held across a burst: ignored while busy, taken in the Done cycle
        hold_evict = 1;
        Evict = 1;
        EvictAddress = 32'h0000_2000;
        set_line(32'hB0);
        step();
        EvictAddress = 32'h0000_3000;
        set_line(32'hC0);
        run_to_done(30, n);
        check("hold_base", BaseAddress, 32'h0000_2000);
        hold_evict = 0;
        step();
        Evict = 0;
        check("b2b_req", 32'(AXIStartWrite), 32'd1);
        check("b2b_base", BaseAddress, 32'h0000_3000);
        run_to_done(30, n);

        // Error response, held until next accepted eviction
        Evict = 1;
        EvictAddress = 32'h0000_4444;
        RespError = 1;
        run_to_done(30, n);
        check("err_set", 32'(Error), 32'd1);
        RespError = 0;
        step();
        step();
        check("err_held", 32'(Error), 32'd1);
        Evict = 1;
        step();
        Evict = 0;
        check("err_clr", 32'(Error), 32'd0);
        run_to_done(30, n);

        // Asynchronous reset after beat 3
        Evict = 1;
        EvictAddress = 32'h0000_5550;
        set_line(32'hD0);
        step();
        Evict = 0;
        for (int i = 0; i < 20 && m_beats != 3; i++) step();
        check("rst_beat", 32'(m_beats), 32'd3);
        #2;
        Rst_n = 0;
        #1;
        model_reset();
        check("rst_async_aw", 32'(AXIStartWrite), 32'd0);
        check("rst_async_wv", 32'(WriteValid), 32'd0);
        check_outputs();
        step();
        step();
        Rst_n = 1;
        step();
        Evict = 1;
        EvictAddress = 32'h0000_6663;
        set_line(32'hE0);
        run_to_done(30, n);
        check("latency_post_rst", 32'(n), 32'd11);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            Evict = ($urandom_range(0, 3) == 0);
            EvictAddress = $urandom;
            for (int i = 0; i < 8; i++) EvictLine[32*i +: 32] = $urandom;
            AddrAccepted = ($urandom_range(0, 2) != 0);
            WriteReady = ($urandom_range(0, 3) != 0);
            RespValid = ($urandom_range(0, 2) != 0);
            RespError = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1)
                SnoopAddress = {m_base[31:3], 3'($urandom_range(0, 7))};
            else
                SnoopAddress = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_buffer.md
# writeback_buffer

Single-entry write-back (eviction) buffer for the data cache: captures a dirty 256-bit line and its address in one cycle, then drains it to memory as an 8-beat, word-granular AXI-style write burst. It is the write-direction counterpart of the linefill path and sits between the cache controller and the AXI master write channels. While draining, it answers address snoops so a concurrent linefill of the same line is served from the buffer instead of from stale memory.

## Interface
- No parameters. Line = 8 words × 32 bits; addresses are word addresses, bits [2:0] select the word within a line.
- Clk  in  1  system clock; all state changes on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Evict  in  1  request to write back a line; sampled only when Ready=1
- EvictAddress  in  32  any word address inside the evicted line
- EvictLine  in  256  line data; word i = EvictLine[32i+31:32i]
- Ready  out  1  buffer empty (state IDLE); an Evict is accepted this cycle
- BaseAddress  out  32  latched line address, {EvictAddress[31:3],3'b000}
- AXIStartWrite  out  1  write-address valid; level, held until AddrAccepted
- AddrAccepted  in  1  memory accepted the burst address
- WriteData  out  32  current beat = buffered word [Counter]
- WriteValid  out  1  WriteData valid
- WriteLast  out  1  final beat (Counter==7 while WriteValid)
- WriteReady  in  1  memory accepted the current beat
- RespValid  in  1  write response present
- RespError  in  1  response is an error; qualified by RespValid
- Done  out  1  one-cycle pulse: burst completed and response received
- Error  out  1  RespError captured with the last response; held until next accepted Evict
- SnoopAddress  in  32  address checked against the buffered line
- SnoopHit  out  1  buffer holds the line containing SnoopAddress
- SnoopData  out  32  buffered word SnoopAddress[2:0]; valid when SnoopHit

## Operation
- States: IDLE, REQUEST, DATA, RESP (2-bit register). Ready, AXIStartWrite, WriteValid are Moore decodes: IDLE, REQUEST, DATA respectively.
- IDLE: Evict=1 → latch EvictLine into the 8×32 buffer, BaseAddress ← aligned address, Counter ← 0, Error ← 0, → REQUEST. Evict ignored in any other state (no queueing; the controller must wait for Ready).
- REQUEST: AXIStartWrite=1; AddrAccepted=1 → DATA.
- DATA: WriteValid=1, WriteData=buffer[Counter]. WriteReady=1 → Counter+1; on WriteReady with Counter==7 → RESP, Counter wraps to 0. No WriteReady → data, Counter, WriteLast stable.
- RESP: RespValid=1 → Error ← RespError, Done ← 1 for the next cycle, → IDLE. RespValid outside RESP is ignored.
- Beats are always emitted in ascending order 0..7 starting at BaseAddress (aligned, no critical-word wrap).
- Snoop: SnoopHit = (state ≠ IDLE) && SnoopAddress[31:3]==BaseAddress[31:3]; SnoopData = buffer[SnoopAddress[2:0]]; both combinational. SnoopHit=0 in IDLE even though buffer contents persist.
- Buffer contents never change outside an accepted Evict.

## Timing
- Reset values: Ready=1, BaseAddress=0, AXIStartWrite=0, WriteValid=0, WriteLast=0, WriteData=0 (buffer cleared), Done=0, Error=0, SnoopHit=0, SnoopData=0, Counter=0, state IDLE.
- Reset mid-burst: all outputs return to reset values immediately (asynchronously); burst abandoned, no Done.
- Evict at edge n → REQUEST in cycle n+1. Minimum Evict-to-Done: 1 (REQUEST) + 8 (DATA) + 1 (RESP) cycles; Done high in cycle n+11, concurrent with Ready=1.
- Done cycle is IDLE: an Evict presented then is accepted (back-to-back evictions, no bubble besides Done).
- AddrAccepted and RespValid in the same cycle as an unrelated state: ignored.
- WriteReady deasserted for k cycles in DATA adds exactly k cycles.

## Test plan
- Evict, EvictAddress=0x0000_1235, EvictLine word i = 0xA0+i, all handshakes tied high → BaseAddress=0x0000_1230, WriteData 0xA0..0xA7 on 8 consecutive cycles, WriteLast only on 0xA7, Done pulse 11 cycles after Evict, Error=0.
- Same with WriteReady low for 3 cycles on beat 4 → beat 4 (0xA4) held stable 4 cycles, WriteLast unchanged, Done delayed by exactly 3 cycles.
- During DATA, SnoopAddress=0x0000_1236 → SnoopHit=1, SnoopData=0xA6; SnoopAddress=0x0000_1246 → SnoopHit=0; after Done, 0x0000_1236 → SnoopHit=0.
- Second Evict while in DATA → ignored (buffer, BaseAddress unchanged); Evict held high through Done cycle → accepted, new burst's REQUEST follows immediately.
- RespValid with RespError=1 → Done pulse, Error=1 held; next accepted Evict clears Error to 0.
- Rst_n low after beat 3 → AXIStartWrite/WriteValid drop without a clock edge, Ready=1, Done never pulses; new Evict after release runs a clean 8-beat burst from word 0.
